head_seq: RTL and testbench

- Instruction sequencer for the head tile engine.
- Fetches 16-bit instructions from instruction memory and decodes them.
- Moves 4x4 tiles (16 words) between weight memory and the systolic array's left and right operand registers.
- Issues multiply, clear and activation commands to the array and writes result tiles back to weight memory.

---
 rtl/head_seq.sv | 211 +++++++++++++++++++++
 tb/tb_head_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/head_seq.sv
// Head tile engine instruction sequencer: fetches 16-bit instructions,
// moves 4x4 tiles between weight memory and the systolic array operand
// registers, drives multiply/clear/activation strobes and stores results.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_FETCH  | present pc on imem_addr
// S_DECODE | instruction word valid; latch ir and dispatch
// S_LOAD   | stream 16 words into left/right operand (cnt 0..16)
// S_MULW   | wait for arr_done, bounded by MUL_TMO
// S_STORE  | write 16 result elements back (cnt 0..15)
// S_HALT   | HALT executed, waiting for start
// S_ERR    | illegal opcode or multiply timeout, waiting for start
module head_seq #(
   parameter int IADDR_W = 8,
   parameter int WADDR_W = 8,
   parameter int DW      = 16,
   parameter int MUL_TMO = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               halted,
   output logic               err,
   output logic [IADDR_W-1:0] pc,
   output logic [IADDR_W-1:0] imem_addr,
   input  logic [15:0]        imem_rdata,
   output logic [WADDR_W-1:0] wmem_addr,
   output logic               wmem_we,
   output logic [DW-1:0]      wmem_wdata,
   input  logic [DW-1:0]      wmem_rdata,
   output logic               arr_ld_l,
   output logic               arr_ld_r,
   output logic [3:0]         arr_idx,
   output logic [DW-1:0]      arr_ld_data,
   output logic               arr_start,
   input  logic               arr_done,
   output logic               arr_clr,
   output logic               arr_act,
   output logic [3:0]         arr_res_idx,
   input  logic [DW-1:0]      arr_res_data
);

   localparam int TMO_W = $clog2(MUL_TMO + 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDL  = 4'h1;
   localparam logic [3:0] OP_LDR  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_STR  = 4'h4;
   localparam logic [3:0] OP_ACT  = 4'h6;
   localparam logic [3:0] OP_CLR  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_MULW, S_STORE, S_HALT, S_ERR
   } state_t;

   state_t             state, state_n;
   logic [IADDR_W-1:0] pc_n;
   logic [15:0]        ir, ir_n;
   logic [4:0]         cnt, cnt_n;
   logic [TMO_W-1:0]   tmo, tmo_n;
   logic [IADDR_W-1:0] pc_inc;
   logic [15:0]        addr16;
   logic [4:0]         cnt_m1;
   logic               unused_addr_hi;

   // Tile address is computed at full operand width, then truncated so it
   // wraps modulo the weight memory size.
   assign addr16         = {ir[15:4], 4'b0000} + {11'b0, cnt};
   assign unused_addr_hi = ^addr16[15:WADDR_W];
   assign cnt_m1         = cnt - 5'd1;
   assign pc_inc         = pc + IADDR_W'(1);

   // State and datapath registers; reset drops every strobe at once because
   // all outputs are decoded from these registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
         cnt   <= '0;
         tmo   <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         ir    <= ir_n;
         cnt   <= cnt_n;
         tmo   <= tmo_n;
      end
   end

   // Next-state logic and output decode.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      ir_n        = ir;
      cnt_n       = cnt;
      tmo_n       = tmo;
      busy        = 1'b1;
      halted      = 1'b0;
      err         = 1'b0;
      imem_addr   = '0;
      wmem_addr   = '0;
      wmem_we     = 1'b0;
      wmem_wdata  = '0;
      arr_ld_l    = 1'b0;
      arr_ld_r    = 1'b0;
      arr_idx     = '0;
      arr_ld_data = '0;
      arr_start   = 1'b0;
      arr_clr     = 1'b0;
      arr_act     = 1'b0;
      arr_res_idx = '0;
      case (state)
         S_IDLE, S_HALT, S_ERR: begin
            busy   = 1'b0;
            halted = (state == S_HALT);
            err    = (state == S_ERR);
            if (start) begin
               pc_n    = '0;
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            imem_addr = pc;
            state_n   = S_DECODE;
         end
         S_DECODE: begin
            ir_n = imem_rdata;
            case (imem_rdata[3:0])
               OP_NOP: begin
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_CLR: begin
                  arr_clr = 1'b1;
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_ACT: begin
                  arr_act = 1'b1;
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_LDL, OP_LDR: begin
                  cnt_n   = '0;
                  state_n = S_LOAD;
               end
               OP_MUL: begin
                  arr_start = 1'b1;
                  tmo_n     = '0;
                  state_n   = S_MULW;
               end
               OP_STR: begin
                  cnt_n   = '0;
                  state_n = S_STORE;
               end
               OP_HALT: state_n = S_HALT;
               default: state_n = S_ERR;
            endcase
         end
         S_LOAD: begin
            // Read address leads the array load by one cycle to cover the
            // synchronous memory latency.
            if (!cnt[4]) wmem_addr = addr16[WADDR_W-1:0];
            if (cnt != 5'd0) begin
               if (ir[3:0] == OP_LDR) arr_ld_r = 1'b1;
               else                   arr_ld_l = 1'b1;
               arr_idx     = cnt_m1[3:0];
               arr_ld_data = wmem_rdata;
            end
            if (cnt == 5'd16) begin
               cnt_n   = '0;
               pc_n    = pc_inc;
               state_n = S_FETCH;
            end else begin
               cnt_n = cnt + 5'd1;
            end
         end
         S_MULW: begin
            if (arr_done) begin
               pc_n    = pc_inc;
               state_n = S_FETCH;
            end else if (tmo == TMO_W'(MUL_TMO - 1)) begin
               state_n = S_ERR;
            end else begin
               tmo_n = tmo + TMO_W'(1);
            end
         end
         S_STORE: begin
            arr_res_idx = cnt[3:0];
            wmem_addr   = addr16[WADDR_W-1:0];
            wmem_we     = 1'b1;
            wmem_wdata  = arr_res_data;
            if (cnt == 5'd15) begin
               cnt_n   = '0;
               pc_n    = pc_inc;
               state_n = S_FETCH;
            end else begin
               cnt_n = cnt + 5'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_head_seq.sv
// Directed bench for head_seq: memory and array models, a table of
// single-instruction programs, and hand sequences for multi-cycle cases.
module tb_head_seq;

   localparam int IW = 8;
   localparam int WW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy, halted, err;
   logic [IW-1:0] pc, imem_addr;
   logic [15:0]   imem_rdata = '0;
   logic [WW-1:0] wmem_addr;
   logic          wmem_we;
   logic [DW-1:0] wmem_wdata;
   logic [DW-1:0] wmem_rdata = '0;
   logic          arr_ld_l, arr_ld_r;
   logic [3:0]    arr_idx;
   logic [DW-1:0] arr_ld_data;
   logic          arr_start;
   logic          arr_done = 1'b0;
   logic          arr_clr, arr_act;
   logic [3:0]    arr_res_idx;
   logic [DW-1:0] arr_res_data;

   head_seq #(.IADDR_W(IW), .WADDR_W(WW), .DW(DW), .MUL_TMO(64)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted),
      .err(err), .pc(pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .wmem_addr(wmem_addr), .wmem_we(wmem_we), .wmem_wdata(wmem_wdata),
      .wmem_rdata(wmem_rdata), .arr_ld_l(arr_ld_l), .arr_ld_r(arr_ld_r),
      .arr_idx(arr_idx), .arr_ld_data(arr_ld_data), .arr_start(arr_start),
      .arr_done(arr_done), .arr_clr(arr_clr), .arr_act(arr_act),
      .arr_res_idx(arr_res_idx), .arr_res_data(arr_res_data)
   );

   always #5 clk = ~clk;

   logic [15:0]   imem [256];
   logic [DW-1:0] wmem [256];
   bit            wvalid [256];
   bit            done_en = 1'b1;
   int            mcnt = 0;

   // Unwritten weight memory reads as addr-15, so mem[16..47] = 1..32.
   function automatic logic [15:0] init_val(input logic [7:0] a);
      return {8'h00, a} - 16'd15;
   endfunction

   always @(posedge clk) begin
      imem_rdata <= imem[imem_addr];
      if (wmem_we) begin
         wmem[wmem_addr]   <= wmem_wdata;
         wvalid[wmem_addr] <= 1'b1;
      end
      wmem_rdata <= wvalid[wmem_addr] ? wmem[wmem_addr] : init_val(wmem_addr);
   end

   // Array model: arr_done pulses for one cycle, the fourth cycle after the
   // edge that sees arr_start.
   always @(posedge clk) begin
      if (arr_start) mcnt <= 1;
      else if (mcnt != 0 && mcnt < 5) mcnt <= mcnt + 1;
      arr_done <= done_en && (mcnt == 4) && !arr_start;
   end

   assign arr_res_data = 16'h0100 + {12'h000, arr_res_idx};

   int n_clr = 0, n_act = 0, n_ldl = 0, n_ldr = 0, n_we = 0, n_st = 0, n_both = 0;
   logic [DW-1:0] left [16];
   logic [DW-1:0] right [16];

   always @(negedge clk) begin
      if (arr_clr)   n_clr <= n_clr + 1;
      if (arr_act)   n_act <= n_act + 1;
      if (arr_ld_l)  n_ldl <= n_ldl + 1;
      if (arr_ld_r)  n_ldr <= n_ldr + 1;
      if (wmem_we)   n_we  <= n_we + 1;
      if (arr_start) n_st  <= n_st + 1;
      if (arr_ld_l && arr_ld_r) n_both <= n_both + 1;
      if (arr_ld_l) left[arr_idx]  <= arr_ld_data;
      if (arr_ld_r) right[arr_idx] <= arr_ld_data;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [79:0] got, input logic [79:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [79:0] outs();
      return {7'b0, busy, halted, err, pc, imem_addr, wmem_addr, wmem_we, wmem_wdata,
              arr_ld_l, arr_ld_r, arr_idx, arr_ld_data, arr_start, arr_clr, arr_act,
              arr_res_idx};
   endfunction

   // Pulse start; cyc counts edges after the one that samples start.
   task automatic run_prog(output int cyc);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!(halted || err) && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   typedef struct {
      logic [15:0] instr;
      bit          den;
      int          cyc;
      bit          er;
      logic [7:0]  pcx;
      int          clr, act, ldl, ldr, we, st;
   } vec_t;

   vec_t vt [12];

   initial begin
      int cyc;
      int c_clr, c_act, c_ldl, c_ldr, c_we, c_st;
      int busy_low;

      //             instr     den cyc er  pc  clr act ldl ldr we  st
      vt[0]  = '{16'h0000, 1'b1,  4, 1'b0, 8'd1, 0, 0,  0,  0,  0, 0};
      vt[1]  = '{16'h0008, 1'b1,  4, 1'b0, 8'd1, 1, 0,  0,  0,  0, 0};
      vt[2]  = '{16'h0006, 1'b1,  4, 1'b0, 8'd1, 0, 1,  0,  0,  0, 0};
      vt[3]  = '{16'h000F, 1'b1,  2, 1'b0, 8'd0, 0, 0,  0,  0,  0, 0};
      vt[4]  = '{16'h0011, 1'b1, 21, 1'b0, 8'd1, 0, 0, 16,  0,  0, 0};
      vt[5]  = '{16'h0022, 1'b1, 21, 1'b0, 8'd1, 0, 0,  0, 16,  0, 0};
      vt[6]  = '{16'h0034, 1'b1, 20, 1'b0, 8'd1, 0, 0,  0,  0, 16, 0};
      vt[7]  = '{16'h0003, 1'b1,  9, 1'b0, 8'd1, 0, 0,  0,  0,  0, 1};
      vt[8]  = '{16'h0003, 1'b0, 66, 1'b1, 8'd0, 0, 0,  0,  0,  0, 1};
      vt[9]  = '{16'h0005, 1'b1,  2, 1'b1, 8'd0, 0, 0,  0,  0,  0, 0};
      vt[10] = '{16'h000E, 1'b1,  2, 1'b1, 8'd0, 0, 0,  0,  0,  0, 0};
      vt[11] = '{16'h0000, 1'b1,  4, 1'b0, 8'd1, 0, 0,  0,  0,  0, 0};

      for (int i = 0; i < 256; i++) imem[i] = 16'h000F;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outs", outs(), 80'h0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_outs", outs(), 80'h0);

      // Full tile program: LDL, LDR, MUL, STR, HALT
      imem[0] = 16'h0011; imem[1] = 16'h0022; imem[2] = 16'h0003;
      imem[3] = 16'h0034; imem[4] = 16'h000F;
      run_prog(cyc);
      check("prog_cycles", 80'(cyc), 80'd65);
      check("prog_halted", 80'(halted), 80'd1);
      check("prog_pc", 80'(pc), 80'd4);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("left[%0d]", i), 80'(left[i]), 80'(i + 1));
         check($sformatf("right[%0d]", i), 80'(right[i]), 80'(i + 17));
         check($sformatf("wmem[%0d]", 48 + i), 80'(wmem[48 + i]), 80'(16'h0100 + i));
      end

      // Single-instruction programs followed by HALT
      for (int v = 0; v < 12; v++) begin
         imem[0] = vt[v].instr;
         imem[1] = 16'h000F;
         done_en = vt[v].den;
         c_clr = n_clr; c_act = n_act; c_ldl = n_ldl;
         c_ldr = n_ldr; c_we = n_we; c_st = n_st;
         run_prog(cyc);
         check($sformatf("v%0d_cycles", v), 80'(cyc), 80'(vt[v].cyc));
         check($sformatf("v%0d_err", v), 80'(err), 80'(vt[v].er));
         check($sformatf("v%0d_halted", v), 80'(halted), 80'(!vt[v].er));
         check($sformatf("v%0d_pc", v), 80'(pc), 80'(vt[v].pcx));
         check($sformatf("v%0d_clr", v), 80'(n_clr - c_clr), 80'(vt[v].clr));
         check($sformatf("v%0d_act", v), 80'(n_act - c_act), 80'(vt[v].act));
         check($sformatf("v%0d_ldl", v), 80'(n_ldl - c_ldl), 80'(vt[v].ldl));
         check($sformatf("v%0d_ldr", v), 80'(n_ldr - c_ldr), 80'(vt[v].ldr));
         check($sformatf("v%0d_we", v), 80'(n_we - c_we), 80'(vt[v].we));
         check($sformatf("v%0d_start", v), 80'(n_st - c_st), 80'(vt[v].st));
      end
      done_en = 1'b1;

      // Tile base wraps within the weight address space
      imem[0] = 16'hFFF1; imem[1] = 16'h000F;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("wrap_addr%0d", i), 80'(wmem_addr), 80'(8'hF0 + i));
         @(negedge clk);
      end
      cyc = 0;
      while (!halted && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("wrap_halted", 80'(halted), 80'd1);

      // Reset in the middle of LOAD
      imem[0] = 16'h0011; imem[1] = 16'h000F;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_ldl", 80'(arr_ld_l), 80'd1);
      check("mid_idx", 80'(arr_idx), 80'd7);
      check("mid_data", 80'(arr_ld_data), 80'd8);
      #1 rst = 1'b0;
      #1 check("rst_async_outs", outs(), 80'h0);
      @(negedge clk); rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_no_restart", outs(), 80'h0);

      // 256 NOPs: pc wraps, start while busy is ignored
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      busy_low = 0;
      for (int k = 1; k <= 512; k++) begin
         @(negedge clk);
         start = (k == 100);
         if (!busy) busy_low++;
         if (k == 200) check("nop_pc_mid", 80'(pc), 80'd100);
         if (k == 510) check("nop_pc_255", 80'(pc), 80'd255);
      end
      start = 1'b0;
      check("nop_pc_wrap", 80'(pc), 80'd0);
      check("nop_busy", 80'(busy_low), 80'd0);
      check("ld_exclusive", 80'(n_both), 80'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
